// File: rtl/edge_cfg_sched.sv
// -----------------------------------------------------------------------------
// edge_cfg_sched
//
// Frame-synchronous configuration scheduler for the edge-detect/cartoon
// pipeline. Filter-mode change requests from the control decoder are accepted
// over a valid/ready handshake and held until the next frame start. At that
// frame start the new filt_sel/en are driven into the pipeline. The output mux
// is then held on the pass-through path for FLUSH_LINES line starts while the
// Gaussian/Sobel line buffers refill with data filtered under the new mode.
//
// Parameters
//   FLUSH_LINES  lines of pass-through after a config change (1..15)
//   RST_FILT     filt_sel value loaded at reset
//
// Ports
//   clk        in   pixel clock, rising edge
//   rst        in   asynchronous active-low reset
//   x_count    in   horizontal pixel counter, 0 = first pixel of a line
//   col        in   line counter, 0 = first line of a frame
//   req_valid  in   a config request is presented
//   req_filt   in   requested filter select
//   req_en     in   requested edge enable
//   req_ready  out  request accepted on a cycle with req_valid && req_ready
//   filt_sel   out  applied filter select
//   en         out  applied edge enable
//   use_pass   out  1 = downstream mux selects pass_thru
//   applied    out  one-cycle pulse when a config becomes live
//   busy       out  high in any state other than RUN
//   state_dbg  out  current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module edge_cfg_sched #(
  parameter int         FLUSH_LINES = 4,
  parameter logic [3:0] RST_FILT    = 4'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] x_count,
  input  logic [12:0] col,
  input  logic        req_valid,
  input  logic [3:0]  req_filt,
  input  logic        req_en,
  output logic        req_ready,
  output logic [3:0]  filt_sel,
  output logic        en,
  output logic        use_pass,
  output logic        applied,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    FLUSH      = 2'd1,
    RUN        = 2'd2,
    PENDING    = 2'd3
  } state_t;

  localparam logic [3:0] FLUSH_CNT = FLUSH_LINES[3:0];

  state_t      state_q, state_d;
  logic [12:0] x_prev_q;
  logic [3:0]  line_cnt_q, line_cnt_d;
  logic [3:0]  pend_filt_q, pend_filt_d;
  logic        pend_en_q, pend_en_d;
  logic [3:0]  filt_q, filt_d;
  logic        en_q, en_d;
  logic        applied_q, applied_d;

  logic        ls;
  logic        fs;
  logic        handshake;
  logic        cfg_differs;

  // Line start is a wrap of the pixel counter back to zero. Comparing against
  // the previous cycle means a counter parked at zero only strobes once.
  assign ls = (x_prev_q != 13'd0) && (x_count == 13'd0);
  assign fs = ls && (col == 13'd0);

  // Handshake: a transfer happens on any cycle where req_valid && req_ready
  // are both high. req_ready is a decode of the state register, so it is
  // stable for the whole cycle and drops on the cycle after a transfer; the
  // requester may change or hold req_filt/req_en freely while req_ready is low.
  assign handshake = req_valid && req_ready;

  assign cfg_differs = ({pend_filt_q, pend_en_q} != {filt_q, en_q});

  always_comb begin
    state_d     = state_q;
    line_cnt_d  = line_cnt_q;
    pend_filt_d = pend_filt_q;
    pend_en_d   = pend_en_q;
    filt_d      = filt_q;
    en_d        = en_q;
    applied_d   = 1'b0;

    unique case (state_q)
      WAIT_FRAME: begin
        if (fs) begin
          state_d    = FLUSH;
          line_cnt_d = 4'd0;
        end
      end

      FLUSH: begin
        // The fs that brought us here was consumed by the transition, so only
        // later line starts (including later frame starts) are counted.
        if (ls) begin
          line_cnt_d = line_cnt_q + 4'd1;
          if (line_cnt_q + 4'd1 == FLUSH_CNT) begin
            state_d   = RUN;
            applied_d = 1'b1;
          end
        end
      end

      RUN: begin
        // A request arriving together with fs is parked; it waits for the
        // following frame start so the current frame is never disturbed.
        if (handshake) begin
          pend_filt_d = req_filt;
          pend_en_d   = req_en;
          state_d     = PENDING;
        end
      end

      PENDING: begin
        if (fs) begin
          if (cfg_differs) begin
            filt_d     = pend_filt_q;
            en_d       = pend_en_q;
            line_cnt_d = 4'd0;
            state_d    = FLUSH;
          end else begin
            // Nothing changes in the pipeline, so the line buffers stay valid
            // and no flush is needed.
            applied_d = 1'b1;
            state_d   = RUN;
          end
        end
      end

      default: begin
        state_d = WAIT_FRAME;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WAIT_FRAME;
      x_prev_q    <= 13'd0;
      line_cnt_q  <= 4'd0;
      pend_filt_q <= 4'd0;
      pend_en_q   <= 1'b0;
      filt_q      <= RST_FILT;
      en_q        <= 1'b0;
      applied_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_prev_q    <= x_count;
      line_cnt_q  <= line_cnt_d;
      pend_filt_q <= pend_filt_d;
      pend_en_q   <= pend_en_d;
      filt_q      <= filt_d;
      en_q        <= en_d;
      applied_q   <= applied_d;
    end
  end

  // All outputs come straight from registers or decodes of the state register.
  assign req_ready = (state_q == RUN);
  assign use_pass  = (state_q == WAIT_FRAME) || (state_q == FLUSH);
  assign busy      = (state_q != RUN);
  assign filt_sel  = filt_q;
  assign en        = en_q;
  assign applied   = applied_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_edge_cfg_sched.sv
// -----------------------------------------------------------------------------
// tb_edge_cfg_sched
//
// Drives a small synthetic raster (short lines, few lines per frame, a random
// 1..3 cycle hold of x_count at zero at each line start) into edge_cfg_sched
// and compares every output on every cycle against a behavioural model: the
// live config, a queue of accepted-but-not-yet-applied configs, a "waiting for
// first frame" flag and a count of flush lines still to go.
// -----------------------------------------------------------------------------
module tb_edge_cfg_sched;

  localparam int         FL      = 4;
  localparam logic [3:0] RF      = 4'h0;
  localparam int         LINE_W  = 12;
  localparam int         FRAME_H = 6;
  localparam int         BOUND   = 3000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] x_count;
  logic [12:0] col;
  logic        req_valid;
  logic [3:0]  req_filt;
  logic        req_en;
  logic        req_ready;
  logic [3:0]  filt_sel;
  logic        en;
  logic        use_pass;
  logic        applied;
  logic        busy;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  edge_cfg_sched #(.FLUSH_LINES(FL), .RST_FILT(RF)) dut (
    .clk       (clk),
    .rst       (rst),
    .x_count   (x_count),
    .col       (col),
    .req_valid (req_valid),
    .req_filt  (req_filt),
    .req_en    (req_en),
    .req_ready (req_ready),
    .filt_sel  (filt_sel),
    .en        (en),
    .use_pass  (use_pass),
    .applied   (applied),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passes = 0;
  int hs_model = 0;
  int hs_dut = 0;
  int app_dut = 0;

  // ---------------- raster generator ----------------
  int px_idx;
  int hold_n;
  int gcol;

  // ---------------- reference model ----------------
  logic [12:0] m_prev_x;
  bit          m_waiting;
  int          m_flush_left;
  logic [4:0]  m_live;
  logic        m_applied;
  logic [4:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic check_bound(input string tag, input int n);
    checks++;
    assert (n < BOUND) passes++;
    else $error("FAIL %s observed=timeout after %0d cycles expected=event", tag, n);
  endtask

  function automatic void model_reset();
    m_prev_x     = 13'd0;
    m_waiting    = 1'b1;
    m_flush_left = 0;
    m_live       = {RF, 1'b0};
    m_applied    = 1'b0;
    exp_q.delete();
  endfunction

  function automatic bit model_ready();
    return !m_waiting && (m_flush_left == 0) && (exp_q.size() == 0);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit         ls;
    bit         fs;
    logic [4:0] cfg;
    ls = (m_prev_x != 13'd0) && (x_count == 13'd0);
    fs = ls && (col == 13'd0);
    m_applied = 1'b0;
    if (m_waiting) begin
      if (fs) begin
        m_waiting    = 1'b0;
        m_flush_left = FL;
      end
    end else if (m_flush_left > 0) begin
      if (ls) begin
        m_flush_left--;
        if (m_flush_left == 0) m_applied = 1'b1;
      end
    end else if (exp_q.size() > 0) begin
      if (fs) begin
        cfg = exp_q.pop_front();
        if (cfg != m_live) begin
          m_live       = cfg;
          m_flush_left = FL;
        end else begin
          m_applied = 1'b1;
        end
      end
    end else if (req_valid) begin
      exp_q.push_back({req_filt, req_en});
      hs_model++;
    end
    m_prev_x = x_count;
  endtask

  task automatic check_outputs();
    check("filt_sel",  32'(filt_sel),  32'(m_live[4:1]));
    check("en",        32'(en),        32'(m_live[0]));
    check("use_pass",  32'(use_pass),  32'(m_waiting || (m_flush_left > 0)));
    check("req_ready", 32'(req_ready), 32'(model_ready()));
    check("busy",      32'(busy),      32'(!model_ready()));
    check("applied",   32'(applied),   32'(m_applied));
  endtask

  // ---------------- driver tasks ----------------
  task automatic gen_apply();
    x_count = (px_idx < hold_n) ? 13'd0 : 13'(px_idx - hold_n + 1);
    col     = 13'(gcol);
  endtask

  task automatic gen_advance();
    px_idx++;
    if (px_idx >= hold_n + LINE_W - 1) begin
      px_idx = 0;
      hold_n = $urandom_range(1, 3);
      gcol   = (gcol + 1) % FRAME_H;
    end
    gen_apply();
  endtask

  task automatic cycle();
    if (rst && req_valid && req_ready) hs_dut++;
    @(posedge clk);
    if (rst) model_edge();
    #1;
    check_outputs();
    if (applied) app_dut++;
    gen_advance();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_ready(input string tag);
    int n = 0;
    while (!model_ready() && n < BOUND) begin
      cycle();
      n++;
    end
    check_bound(tag, n);
  endtask

  // Stop with the inputs for an fs cycle currently applied.
  task automatic run_until_fs_now(input string tag);
    int n = 0;
    while (!(m_prev_x != 13'd0 && x_count == 13'd0 && col == 13'd0) && n < BOUND) begin
      cycle();
      n++;
    end
    check_bound(tag, n);
  endtask

  task automatic run_until_pos(input int line, input int x, input string tag);
    int n = 0;
    while (!(col == 13'(line) && x_count == 13'(x)) && n < BOUND) begin
      cycle();
      n++;
    end
    check_bound(tag, n);
  endtask

  task automatic send_req(input logic [3:0] f, input logic e);
    req_valid = 1'b1;
    req_filt  = f;
    req_en    = e;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check({tag, "_filt"},    32'(filt_sel),  32'(RF));
    check({tag, "_en"},      32'(en),        32'd0);
    check({tag, "_pass"},    32'(use_pass),  32'd1);
    check({tag, "_ready"},   32'(req_ready), 32'd0);
    check({tag, "_applied"}, 32'(applied),   32'd0);
    check({tag, "_busy"},    32'(busy),      32'd1);
    run_cycles(3);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         base;
    logic [4:0] old_cfg;
    logic [3:0] nf;
    logic       ne;

    rst       = 1'b0;
    req_valid = 1'b0;
    req_filt  = 4'h0;
    req_en    = 1'b0;
    px_idx    = 0;
    hold_n    = 1;
    gcol      = 0;
    gen_apply();
    model_reset();

    // Reset values, then the start-up WAIT_FRAME/FLUSH sequence.
    run_cycles(3);
    check("reset_use_pass", 32'(use_pass), 32'd1);
    check("reset_filt_sel", 32'(filt_sel), 32'(RF));
    @(negedge clk);
    rst = 1'b1;
    base = app_dut;
    run_until_ready("startup_ready");
    check("startup_applied_cnt", 32'(app_dut - base), 32'd1);
    check("startup_use_pass", 32'(use_pass), 32'd0);

    // Change to filt 3 / en 1 mid-frame; applies at the next frame start.
    run_until_pos(3, 5, "reach_line3");
    send_req(4'h3, 1'b1);
    check("req_ready_drop", 32'(req_ready), 32'd0);
    check("filt_held_midframe", 32'(filt_sel), 32'(RF));
    run_until_fs_now("fs_after_req");
    cycle();
    check("cfg_filt_after_fs", 32'(filt_sel), 32'd3);
    check("cfg_en_after_fs",   32'(en),       32'd1);
    check("cfg_pass_after_fs", 32'(use_pass), 32'd1);
    base = app_dut;
    run_until_ready("flush_done_1");
    check("flush1_applied_cnt", 32'(app_dut - base), 32'd1);

    // Request identical to the live config: pulse only, no flush.
    run_cycles(7);
    send_req(4'h3, 1'b1);
    run_until_fs_now("fs_same_cfg");
    cycle();
    check("same_cfg_applied",  32'(applied),  32'd1);
    check("same_cfg_use_pass", 32'(use_pass), 32'd0);
    check("same_cfg_filt",     32'(filt_sel), 32'd3);

    // req_valid held high with changing data for several frames.
    req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      req_filt = 4'($urandom);
      req_en   = 1'($urandom);
      cycle();
    end
    req_valid = 1'b0;
    check("held_valid_handshakes", 32'(hs_dut), 32'(hs_model));
    run_until_ready("after_held_valid");

    // Handshake on the fs cycle itself: applies one frame later.
    run_until_fs_now("fs_for_same_cycle_req");
    old_cfg = m_live;
    nf = m_live[4:1] ^ 4'h5;
    ne = ~m_live[0];
    send_req(nf, ne);
    check("fs_req_filt_unchanged", 32'(filt_sel), 32'(old_cfg[4:1]));
    check("fs_req_pass_low",       32'(use_pass), 32'd0);
    run_until_fs_now("next_fs");
    cycle();
    check("fs_req_filt_applied", 32'(filt_sel), 32'(nf));
    check("fs_req_en_applied",   32'(en),       32'(ne));
    check("fs_req_pass_high",    32'(use_pass), 32'd1);
    run_until_ready("flush_done_2");

    // Random traffic.
    for (int i = 0; i < 900; i++) begin
      req_valid = ($urandom_range(0, 5) == 0);
      req_filt  = 4'($urandom);
      req_en    = 1'($urandom);
      cycle();
    end
    req_valid = 1'b0;
    check("random_handshakes", 32'(hs_dut), 32'(hs_model));

    // Reset in the middle of a flush.
    run_until_ready("pre_flush_reset");
    send_req(m_live[4:1] ^ 4'hA, m_live[0]);
    run_until_fs_now("fs_pre_flush_reset");
    cycle();
    run_cycles(20);
    async_reset("rst_flush");
    base = app_dut;
    run_until_ready("startup_after_rst1");
    check("rst1_applied_cnt", 32'(app_dut - base), 32'd1);
    check("rst1_filt", 32'(filt_sel), 32'(RF));

    // Reset while a request is pending: the request must be lost.
    send_req(4'hC, 1'b1);
    run_cycles(4);
    async_reset("rst_pending");
    run_until_ready("startup_after_rst2");
    run_until_fs_now("fs_after_rst2");
    cycle();
    check("rst2_pend_lost_filt", 32'(filt_sel), 32'(RF));
    check("rst2_pend_lost_pass", 32'(use_pass), 32'd0);
    run_cycles(10);

    $display("final state code %0d", state_dbg);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
